// File: rtl/cardet_pkg.sv
// Shared sizing helpers for the clock-enable receive path.
// Counters hold 0..DEPTH inclusive, so they need one more bit than pointers.
package cardet_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int PTR_W         = $clog2(DEFAULT_DEPTH);

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ce_fifo_mem.sv
// N x DEPTH register array: synchronous write, asynchronous read, synchronous clear.
// Clearing on reset keeps odata at 0 while the FIFO is empty after reset.
module ce_fifo_mem #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ce_stream_reader.sv
// Captures ce-qualified words into a FWFT FIFO and hands them to a valid/ready consumer.
// hold warns upstream early; ovf latches any word lost while full.
module ce_stream_reader
    import cardet_pkg::*;
#(
    parameter int N           = 8,
    parameter int DEPTH       = 4,
    parameter int HOLD_MARGIN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic [N-1:0]               idata,
    output logic                       hold,
    output logic                       ovf,
    output logic [N-1:0]               odata,
    output logic                       ovalid,
    input  logic                       oready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] HOLD_LVL = CW'(DEPTH - HOLD_MARGIN);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, rd, wr_ok, drop;

    assign ovalid = (count != '0);
    assign full   = (count == FULL_LVL);
    assign rd     = ovalid & oready;
    // A full FIFO can still accept a write when the head leaves in the same cycle.
    assign wr_ok  = ce & (~full | rd);
    assign drop   = ce & full & ~rd;
    assign hold   = (count >= HOLD_LVL);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd)    rd_ptr <= rd_ptr + AW'(1);
            if (wr_ok && !rd)      count <= count + CW'(1);
            else if (rd && !wr_ok) count <= count - CW'(1);
            if (drop) ovf <= 1'b1;
        end
    end

    ce_fifo_mem #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (idata),
        .raddr (rd_ptr),
        .rdata (odata)
    );

endmodule

// File: tb/tb_ce_stream_reader.sv
// Directed vector table for the corner cases, then randomized streaming against a queue model.
module tb_ce_stream_reader;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int HM    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst, ce, oready, hold, ovf, ovalid;
    logic [N-1:0]  idata, odata;
    logic [CW-1:0] count;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    ce_stream_reader #(.N(N), .DEPTH(DEPTH), .HOLD_MARGIN(HM)) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .idata  (idata),
        .hold   (hold),
        .ovf    (ovf),
        .odata  (odata),
        .ovalid (ovalid),
        .oready (oready),
        .count  (count)
    );

    typedef struct {
        logic         rst;
        logic         ce;
        logic [7:0]   idata;
        logic         oready;
        logic         chk_od;
        logic         ovalid;
        logic [7:0]   odata;
        logic [2:0]   count;
        logic         hold;
        logic         ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a queue of stored words plus a sticky drop flag.
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;

    task automatic run(input int words, input int max_cyc, input bit obey_hold,
                       input int ce_pct, input int rdy_pct, input string tag);
        int  sent = 0;
        int  cyc  = 0;
        bit  full, rdq;
        while (sent < words && cyc < max_cyc) begin
            chk({tag, "_ovalid"}, ovalid, q.size() != 0);
            chk({tag, "_count"}, count, q.size());
            chk({tag, "_hold"}, hold, q.size() >= DEPTH - HM);
            chk({tag, "_ovf"}, ovf, m_ovf);
            if (q.size() != 0) chk({tag, "_odata"}, odata, q[0]);
            if (obey_hold) ce = (q.size() < DEPTH - HM);
            else           ce = ($urandom_range(99, 0) < ce_pct);
            idata  = 8'($urandom);
            oready = ($urandom_range(99, 0) < rdy_pct);
            full = (q.size() == DEPTH);
            rdq  = (q.size() != 0) && oready;
            if (rdq) void'(q.pop_front());
            if (ce) begin
                if (!full || rdq) begin
                    q.push_back(idata);
                    sent++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            step();
            cyc++;
        end
        if (sent < words) chk({tag, "_budget"}, sent, words);
        ce = 1'b0;
        oready = 1'b0;
    endtask

    vec_t tv[$];

    initial begin
        rst = 1'b1; ce = 1'b0; idata = '0; oready = 1'b0;
        //          rst ce idata oready chk_od ovalid odata count hold ovf
        tv.push_back('{1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0});  // reset state
        tv.push_back('{0, 1, 8'h5A, 0, 1, 1, 8'h5A, 1, 0, 0});  // single word
        tv.push_back('{0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0});  // consume it
        tv.push_back('{0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0});  // oready ignored when empty
        tv.push_back('{1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0});
        tv.push_back('{0, 1, 8'h01, 0, 1, 1, 8'h01, 1, 0, 0});  // fill
        tv.push_back('{0, 1, 8'h02, 0, 1, 1, 8'h01, 2, 0, 0});
        tv.push_back('{0, 1, 8'h03, 0, 1, 1, 8'h01, 3, 1, 0});  // hold after 3rd
        tv.push_back('{0, 1, 8'h04, 0, 1, 1, 8'h01, 4, 1, 0});
        tv.push_back('{0, 1, 8'hFF, 0, 1, 1, 8'h01, 4, 1, 1});  // overflow drop
        tv.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h02, 3, 1, 1});  // drain
        tv.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h03, 2, 0, 1});
        tv.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h04, 1, 0, 1});
        tv.push_back('{0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1});  // ovf sticky
        tv.push_back('{1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0});  // only rst clears
        tv.push_back('{0, 1, 8'h01, 0, 1, 1, 8'h01, 1, 0, 0});
        tv.push_back('{0, 1, 8'h02, 0, 1, 1, 8'h01, 2, 0, 0});
        tv.push_back('{0, 1, 8'h03, 0, 1, 1, 8'h01, 3, 1, 0});
        tv.push_back('{0, 1, 8'h04, 0, 1, 1, 8'h01, 4, 1, 0});
        tv.push_back('{0, 1, 8'h05, 1, 1, 1, 8'h02, 4, 1, 0});  // full, read+write
        tv.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h03, 3, 1, 0});
        tv.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h04, 2, 0, 0});
        tv.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h05, 1, 0, 0});
        tv.push_back('{0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0});
        tv.push_back('{0, 1, 8'h11, 0, 1, 1, 8'h11, 1, 0, 0});
        tv.push_back('{0, 1, 8'h22, 0, 1, 1, 8'h11, 2, 0, 0});
        tv.push_back('{0, 1, 8'h33, 0, 1, 1, 8'h11, 3, 1, 0});
        tv.push_back('{1, 1, 8'h44, 0, 1, 0, 8'h00, 0, 0, 0});  // rst with ce
        tv.push_back('{0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0});  // ce during rst ignored

        step();
        for (int i = 0; i < tv.size(); i++) begin
            rst    = tv[i].rst;
            ce     = tv[i].ce;
            idata  = tv[i].idata;
            oready = tv[i].oready;
            step();
            chk($sformatf("v%0d_ovalid", i), ovalid, tv[i].ovalid);
            chk($sformatf("v%0d_count", i), count, tv[i].count);
            chk($sformatf("v%0d_hold", i), hold, tv[i].hold);
            chk($sformatf("v%0d_ovf", i), ovf, tv[i].ovf);
            if (tv[i].chk_od) chk($sformatf("v%0d_odata", i), odata, tv[i].odata);
        end
        rst = 1'b0; ce = 1'b0; oready = 1'b0;

        // Bring the model in step with a fresh reset before random traffic.
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;

        run(1000, 20000, 1'b1, 100, 50, "stream");
        chk("stream_no_ovf", ovf, 1'b0);
        run(400, 4000, 1'b0, 80, 30, "ovfmix");
        chk("ovfmix_final_ovf", ovf, m_ovf);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/ce_stream_reader.md
# ce_stream_reader

Receive end of the clock-enable pixel pipeline. Upstream stages advance data only on `ce`, with no way to stall. This block captures each `ce`-qualified word into a small FIFO and presents it to a downstream consumer over a valid/ready handshake. It raises `hold` so the upstream `ce` source can pause early, and keeps a sticky overflow flag for words lost when the FIFO is full.

## Interface
Parameters:
- `N`, 8, data word width (≥1)
- `DEPTH`, 4, FIFO depth in words; power of 2, ≥2
- `HOLD_MARGIN`, 1, free slots remaining when `hold` asserts; range 0..DEPTH-1 (0 = hold only when full)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `ce`  in  1  upstream enable; `idata` is valid in a cycle with `ce`=1
- `idata`  in  N  upstream word
- `hold`  out  1  request to upstream to stop issuing `ce`
- `ovf`  out  1  sticky: a word was dropped
- `odata`  out  N  head-of-FIFO word
- `ovalid`  out  1  `odata` holds a valid word
- `oready`  in  1  consumer accepts `odata` this cycle
- `count`  out  $clog2(DEPTH+1)  words currently stored

## Operation
- Write request `wr = ce`. Read `rd = ovalid & oready`.
- Registered state: `count`, `wr_ptr`, `rd_ptr` (log2(DEPTH) bits, wrap naturally), storage array, `ovf`.
- **Empty (`count`=0):**
  - `ovalid`=0.
  - `oready` is ignored; no read happens.
  - A write in the same cycle still succeeds.
- **Normal:**
  - A write stores `idata` at `wr_ptr`, then advances `wr_ptr`.
  - A read advances `rd_ptr`.
  - `count` changes by +1 on write only, −1 on read only, and is unchanged on simultaneous read and write.
- **Full (`count`=DEPTH):**
  - `ce` with a read in the same cycle: the write is accepted and `count` stays at DEPTH.
  - `ce` with no read: `idata` is dropped, storage and pointers are unchanged, and `ovf` sets to 1.
  - `ovf` clears only on `rst`.
- **First-word-fall-through:**
  - `odata` = storage[`rd_ptr`] whenever `ovalid`=1.
  - `ovalid` = (`count` != 0).
- `hold` = (`count` ≥ DEPTH − HOLD_MARGIN), decoded from the registered `count`. Upstream may ignore `hold`; the overflow rule above still applies.
- **Order:** words leave in exactly the order they were written with `ce`. Dropped words never appear on `odata`.
- **Reset:**
  - `count`=0, both pointers 0, `ovf`=0, all storage 0.
  - Outputs after reset: `ovalid`=0, `hold`=0 (`hold`=1 only if DEPTH−HOLD_MARGIN=0, which the parameter range excludes), `odata`=0.
  - Reset mid-stream discards all stored words. A `ce` in the same cycle as `rst` is ignored.

## Timing
- Write latency: `ce` at edge t puts the word at the head of an empty FIFO with `ovalid`=1 from cycle t+1. There is no combinational path from `ce`/`idata` to `ovalid`/`odata`.
- Throughput: one word per cycle in and out sustained, with no bubbles at any fill level.
- **Read:**
  - When `ovalid` and `oready` are both high at edge t, the next word, if any, is on `odata` in cycle t+1.
  - `odata` is stable while `ovalid`=1 and `oready`=0.
- `hold` and `count` update one cycle after the write/read that changes them.
- The only combinational input-to-output path is none. `oready` affects state only.

## Structure
- Shared package `cardet_pkg`: count width function (`$clog2(DEPTH+1)`) and pointer width constant.
- One sub-module, `ce_fifo_mem`: parameterised N×DEPTH register array with synchronous write port (`we`, `waddr`, `wdata`), asynchronous read (`raddr` → `rdata`), and synchronous reset to 0.
- Control (pointers, count, `ovf`, `hold`) lives in `ce_stream_reader`.

## Test plan
- **Reset then single word:** after `rst`, drive `ce`=1 with `idata`=0x5A for 1 cycle and `oready`=0. Next cycle: `ovalid`=1, `odata`=0x5A, `count`=1. Pulse `oready`. One cycle later: `ovalid`=0, `count`=0.
- **Fill to full (DEPTH=4, HOLD_MARGIN=1):** write 0x01..0x04 on consecutive cycles with `oready`=0.
  - `hold` rises the cycle after the 3rd write.
  - `count`=4 after the 4th.
  - Drain with `oready`=1: `odata` sequence is 01, 02, 03, 04.
- **Overflow:** with the FIFO full and `oready`=0, write 0xFF. Then `ovf`=1 and `count`=4, and the drain yields 01..04 only. `ovf` stays 1 until `rst`.
- **Full with simultaneous read/write:** with the FIFO full of 01..04, `ce`=1 with `idata`=0x05 and `oready`=1 in the same cycle. Then `ovf`=0, `count`=4, and the drain yields 02, 03, 04, 05.
- **Streaming with random `oready` (~50%):** `ce` every cycle, respecting `hold`, for 1000 words. The output sequence equals the input sequence, with no loss and `ovf`=0. Pointer wrap is exercised.
- **Reset mid-stream:** with `count`=3, assert `rst` in the same cycle as `ce`=1. Next cycle: `count`=0, `ovalid`=0, `odata`=0, `ovf`=0.
